// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending credit datapath: FSM state encoding
// and a width-generic saturating adder.
package vend_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DISPENSE = 2'd1,
      CHANGE   = 2'd2
   } vend_state_t;

   // Works on 32-bit containers; the caller slices the low w bits (w <= 31).
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned w);
      logic [32:0] s;
      logic [32:0] lim;
      s   = {1'b0, a} + {1'b0, b};
      lim = (33'd1 << w) - 33'd1;
      return (s > lim) ? lim[31:0] : s[31:0];
   endfunction

endpackage

// File: rtl/vend_cmp.sv
// Unsigned magnitude comparator; the greater-or-equal result drives the
// "enough credit" flag.
module vend_cmp #(
   parameter int W = 8
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic         o_ge
);

   logic w_gt;
   logic w_eq;

   assign w_gt = (i_a > i_b);
   assign w_eq = (i_a == i_b);
   assign o_ge = w_gt | w_eq;

endmodule

// File: rtl/vend_price_table.sv
// N x W price register file: synchronous write, asynchronous read, every
// entry reloaded with PRICE_DEF on reset.
module vend_price_table #(
   parameter  int W         = 8,
   parameter  int N         = 4,
   parameter  int PRICE_DEF = 5,
   localparam int SW        = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_we,
   input  logic [SW-1:0] i_wr_idx,
   input  logic [W-1:0]  i_wr_data,
   input  logic [SW-1:0] i_rd_idx,
   output logic [W-1:0]  o_rd_data
);

   logic [W-1:0] r_price [N];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            r_price[i] <= W'(PRICE_DEF);
         end
      end else if (i_we) begin
         r_price[i_wr_idx] <= i_wr_data;
      end
   end

   assign o_rd_data = r_price[i_rd_idx];

endmodule

// File: rtl/vend_multi_datapath.sv
// Vending credit datapath with its control FSM (IDLE/DISPENSE/CHANGE).
// Define CHANGE_RETURN_EN to enable change return and cancel/refund.
module vend_multi_datapath
   import vend_pkg::*;
#(
   parameter  int W         = 8,
   parameter  int N         = 4,
   parameter  int PRICE_DEF = 5,
   localparam int SW        = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          coin_valid,
   input  logic [W-1:0]  coin_val,
   output logic          coin_rej,
   input  logic [SW-1:0] sel,
   input  logic          buy,
   input  logic          cancel,
   input  logic          price_we,
   input  logic [SW-1:0] price_idx,
   input  logic [W-1:0]  price_data,
   output logic [W-1:0]  tot,
   output logic          tm,
   output logic          busy,
   output logic          disp_valid,
   output logic [SW-1:0] disp_idx,
   input  logic          disp_ready,
   output logic          chg_valid,
   output logic [W-1:0]  chg_val,
   input  logic          chg_ready
);

   // Handshakes: a transfer happens on any cycle where valid & ready are both
   // high; valid and its payload are held unchanged until that cycle.

   vend_state_t  r_state;
   logic [W-1:0] r_tot;
   logic         r_coin_rej;
   logic         r_disp_valid;
   logic [SW-1:0] r_disp_idx;
   logic [W-1:0] w_price;
   logic         w_ge;
   logic [31:0]  w_sum_wide;
   logic         w_unused_sum_hi;

   vend_price_table #(.W(W), .N(N), .PRICE_DEF(PRICE_DEF)) u_price (
      .clk       (clk),
      .rst       (rst),
      .i_we      (price_we),
      .i_wr_idx  (price_idx),
      .i_wr_data (price_data),
      .i_rd_idx  (sel),
      .o_rd_data (w_price)
   );

   vend_cmp #(.W(W)) u_cmp (
      .i_a  (r_tot),
      .i_b  (w_price),
      .o_ge (w_ge)
   );

   assign w_sum_wide      = sat_add(32'(r_tot), 32'(coin_val), W);
   assign w_unused_sum_hi = ^w_sum_wide[31:W];

`ifdef CHANGE_RETURN_EN
   logic         r_chg_valid;
   logic [W-1:0] r_chg_val;
   assign chg_valid = r_chg_valid;
   assign chg_val   = r_chg_val;
`else
   logic w_unused_ctl;
   assign w_unused_ctl = cancel ^ chg_ready;
   assign chg_valid    = 1'b0;
   assign chg_val      = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_tot        <= '0;
         r_coin_rej   <= 1'b0;
         r_disp_valid <= 1'b0;
         r_disp_idx   <= '0;
`ifdef CHANGE_RETURN_EN
         r_chg_valid  <= 1'b0;
         r_chg_val    <= '0;
`endif
      end else begin
         r_coin_rej <= 1'b0;
         case (r_state)
            IDLE: begin
`ifdef CHANGE_RETURN_EN
               if (cancel && (r_tot != '0)) begin
                  r_chg_val   <= r_tot;
                  r_chg_valid <= 1'b1;
                  r_coin_rej  <= coin_valid;
                  r_state     <= CHANGE;
               end else
`endif
               if (buy && w_ge) begin
                  r_disp_idx   <= sel;
                  r_tot        <= r_tot - w_price;
                  r_disp_valid <= 1'b1;
                  r_coin_rej   <= coin_valid;
                  r_state      <= DISPENSE;
               end else if (coin_valid) begin
                  r_tot <= w_sum_wide[W-1:0];
               end
            end
            DISPENSE: begin
               r_coin_rej <= coin_valid;
               if (disp_ready) begin
                  r_disp_valid <= 1'b0;
`ifdef CHANGE_RETURN_EN
                  if (r_tot != '0) begin
                     r_chg_val   <= r_tot;
                     r_chg_valid <= 1'b1;
                     r_state     <= CHANGE;
                  end else
`endif
                  r_state <= IDLE;
               end
            end
            CHANGE: begin
               r_coin_rej <= coin_valid;
`ifdef CHANGE_RETURN_EN
               if (chg_ready) begin
                  r_chg_valid <= 1'b0;
                  r_chg_val   <= '0;
                  r_tot       <= '0;
                  r_state     <= IDLE;
               end
`else
               r_state <= IDLE;
`endif
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign tot        = r_tot;
   assign tm         = w_ge;
   assign busy       = (r_state != IDLE);
   assign coin_rej   = r_coin_rej;
   assign disp_valid = r_disp_valid;
   assign disp_idx   = r_disp_idx;

endmodule

// File: tb/tb_vend_multi_datapath.sv
// Table-driven bench for vend_multi_datapath (W=8, N=4, PRICE_DEF=5); each
// record holds one cycle of inputs and the outputs expected after that edge.
module tb_vend_multi_datapath;

   localparam int W = 8;
   localparam int N = 4;
   localparam int SW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          coin_valid;
   logic [W-1:0]  coin_val;
   logic          coin_rej;
   logic [SW-1:0] sel;
   logic          buy;
   logic          cancel;
   logic          price_we;
   logic [SW-1:0] price_idx;
   logic [W-1:0]  price_data;
   logic [W-1:0]  tot;
   logic          tm;
   logic          busy;
   logic          disp_valid;
   logic [SW-1:0] disp_idx;
   logic          disp_ready;
   logic          chg_valid;
   logic [W-1:0]  chg_val;
   logic          chg_ready;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic          rst;
      logic          cv;
      logic [W-1:0]  cval;
      logic [SW-1:0] sel;
      logic          buy;
      logic          cancel;
      logic          pwe;
      logic [SW-1:0] pidx;
      logic [W-1:0]  pdata;
      logic          dr;
      logic          cr;
      logic [W-1:0]  e_tot;
      logic          e_tm;
      logic          e_busy;
      logic          e_dv;
      logic [SW-1:0] e_di;
      logic          e_chv;
      logic [W-1:0]  e_chval;
      logic          e_rej;
   } vec_t;

   vec_t vecs[$];

   vend_multi_datapath #(.W(W), .N(N), .PRICE_DEF(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .coin_valid (coin_valid),
      .coin_val   (coin_val),
      .coin_rej   (coin_rej),
      .sel        (sel),
      .buy        (buy),
      .cancel     (cancel),
      .price_we   (price_we),
      .price_idx  (price_idx),
      .price_data (price_data),
      .tot        (tot),
      .tm         (tm),
      .busy       (busy),
      .disp_valid (disp_valid),
      .disp_idx   (disp_idx),
      .disp_ready (disp_ready),
      .chg_valid  (chg_valid),
      .chg_val    (chg_val),
      .chg_ready  (chg_ready)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(
      input logic rs, input logic cv, input int cval, input int s,
      input logic b, input logic c, input logic pwe, input int pidx, input int pdata,
      input logic dr, input logic cr,
      input int etot, input logic etm, input logic ebusy, input logic edv,
      input int edi, input logic echv, input int echval, input logic erej);
      vec_t v;
      v.rst = rs; v.cv = cv; v.cval = W'(cval); v.sel = SW'(s);
      v.buy = b; v.cancel = c; v.pwe = pwe; v.pidx = SW'(pidx); v.pdata = W'(pdata);
      v.dr = dr; v.cr = cr;
      v.e_tot = W'(etot); v.e_tm = etm; v.e_busy = ebusy; v.e_dv = edv;
      v.e_di = SW'(edi); v.e_chv = echv; v.e_chval = W'(echval); v.e_rej = erej;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s vec=%0d got=%0d want=%0d", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst        = v.rst;
      coin_valid = v.cv;
      coin_val   = v.cval;
      sel        = v.sel;
      buy        = v.buy;
      cancel     = v.cancel;
      price_we   = v.pwe;
      price_idx  = v.pidx;
      price_data = v.pdata;
      disp_ready = v.dr;
      chg_ready  = v.cr;
   endtask

   task automatic build_table();
      // Test 1: coins 2,2,1 then buy product 0 with exact credit.
      vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,   0,0,0,0,0,0,0,0));
      vecs.push_back(mk(0,1,2,0,0,0,0,0,0,0,0,   2,0,0,0,0,0,0,0));
      vecs.push_back(mk(0,1,2,0,0,0,0,0,0,0,0,   4,0,0,0,0,0,0,0));
      vecs.push_back(mk(0,1,1,0,0,0,0,0,0,0,0,   5,1,0,0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,1,0,0,0,0,0,0,   0,0,1,1,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,0,   0,0,0,0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,   0,0,0,0,0,0,0,0));
      // Test 2: price[1]=7, coins 5,5, buy product 1 leaves 3.
      vecs.push_back(mk(0,0,0,1,0,0,1,1,7,0,0,   0,0,0,0,0,0,0,0));
      vecs.push_back(mk(0,1,5,1,0,0,0,0,0,0,0,   5,0,0,0,0,0,0,0));
      vecs.push_back(mk(0,1,5,1,0,0,0,0,0,0,0,  10,1,0,0,0,0,0,0));
      vecs.push_back(mk(0,0,0,1,1,0,0,0,0,0,0,   3,0,1,1,1,0,0,0));
`ifdef CHANGE_RETURN_EN
      vecs.push_back(mk(0,0,0,1,0,0,0,0,0,1,0,   3,0,1,0,1,1,3,0));
      vecs.push_back(mk(0,0,0,1,0,0,0,0,0,0,0,   3,0,1,0,1,1,3,0));
      vecs.push_back(mk(0,0,0,1,0,0,0,0,0,0,1,   0,0,0,0,1,0,0,0));
`else
      vecs.push_back(mk(0,0,0,1,0,0,0,0,0,1,0,   3,0,0,0,1,0,0,0));
      vecs.push_back(mk(0,0,0,1,0,1,0,0,0,0,0,   3,0,0,0,1,0,0,0));
`endif
      // Test 3/4: saturation, then a 10-cycle stall with a rejected coin.
      vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,   0,0,0,0,0,0,0,0));
      vecs.push_back(mk(0,1,200,0,0,0,0,0,0,0,0, 200,1,0,0,0,0,0,0));
      vecs.push_back(mk(0,1,100,0,0,0,0,0,0,0,0, 255,1,0,0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,1,0,0,0,0,0,0, 250,1,1,1,0,0,0,0));
      for (int i = 0; i < 10; i++) begin
         vecs.push_back(mk(0, i == 3, 2, 2, 1, 1, 0,0,0, 0, 0,
                           250, 1, 1, 1, 0, 0, 0, i == 3));
      end
`ifdef CHANGE_RETURN_EN
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,0, 250,1,1,0,0,1,250,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,   0,0,0,0,0,0,0,0));
`else
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,0, 250,1,0,0,0,0,0,0));
`endif
      // Test 5: buy with too little credit, then cancel+buy together.
      vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,   0,0,0,0,0,0,0,0));
      vecs.push_back(mk(0,1,4,0,0,0,0,0,0,0,0,   4,0,0,0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,1,0,0,0,0,0,0,   4,0,0,0,0,0,0,0));
      vecs.push_back(mk(0,1,2,0,0,0,0,0,0,0,0,   6,1,0,0,0,0,0,0));
`ifdef CHANGE_RETURN_EN
      vecs.push_back(mk(0,0,0,0,1,1,0,0,0,0,0,   6,1,1,0,0,1,6,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,   0,0,0,0,0,0,0,0));
`else
      vecs.push_back(mk(0,0,0,0,1,1,0,0,0,0,0,   1,0,1,1,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,0,   1,0,0,0,0,0,0,0));
`endif
      // Cancel on zero credit is ignored; a coin alongside an accepted buy is rejected.
      vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,   0,0,0,0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,1,0,0,0,0,0,   0,0,0,0,0,0,0,0));
      vecs.push_back(mk(0,1,5,0,0,0,0,0,0,0,0,   5,1,0,0,0,0,0,0));
      vecs.push_back(mk(0,1,3,0,1,0,0,0,0,0,0,   0,0,1,1,0,0,0,1));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,0,   0,0,0,0,0,0,0,0));
      // A price write during DISPENSE must not alter the amount already deducted.
      vecs.push_back(mk(0,1,8,0,0,0,0,0,0,0,0,   8,1,0,0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,1,0,0,0,0,0,0,   3,0,1,1,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,1,0,1,0,0,   3,1,1,1,0,0,0,0));
`ifdef CHANGE_RETURN_EN
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,0,   3,1,1,0,0,1,3,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,   0,0,0,0,0,0,0,0));
`else
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,0,   3,1,0,0,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,   0,0,0,0,0,0,0,0));
`endif
      // Test 6: price[2]=1, credit 7, then reset mid-transaction.
      vecs.push_back(mk(0,0,0,2,0,0,1,2,1,0,0,   0,0,0,0,0,0,0,0));
      vecs.push_back(mk(0,1,7,2,0,0,0,0,0,0,0,   7,1,0,0,0,0,0,0));
`ifdef CHANGE_RETURN_EN
      vecs.push_back(mk(0,0,0,2,0,1,0,0,0,0,0,   7,1,1,0,0,1,7,0));
      vecs.push_back(mk(0,0,0,2,0,0,0,0,0,0,0,   7,1,1,0,0,1,7,0));
`else
      vecs.push_back(mk(0,0,0,2,1,0,0,0,0,0,0,   6,1,1,1,2,0,0,0));
      vecs.push_back(mk(0,0,0,2,0,0,0,0,0,0,0,   6,1,1,1,2,0,0,0));
`endif
      vecs.push_back(mk(1,0,0,2,0,0,0,0,0,0,0,   0,0,0,0,0,0,0,0));
      vecs.push_back(mk(0,1,3,2,0,0,0,0,0,0,0,   3,0,0,0,0,0,0,0));
   endtask

   initial begin
      drive(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
      build_table();
      repeat (2) @(posedge clk);
      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i]);
         @(posedge clk);
         #1;
         chk("tot",        i, int'(tot),        int'(vecs[i].e_tot));
         chk("tm",         i, int'(tm),         int'(vecs[i].e_tm));
         chk("busy",       i, int'(busy),       int'(vecs[i].e_busy));
         chk("disp_valid", i, int'(disp_valid), int'(vecs[i].e_dv));
         chk("disp_idx",   i, int'(disp_idx),   int'(vecs[i].e_di));
         chk("chg_valid",  i, int'(chg_valid),  int'(vecs[i].e_chv));
         chk("chg_val",    i, int'(chg_val),    int'(vecs[i].e_chval));
         chk("coin_rej",   i, int'(coin_rej),   int'(vecs[i].e_rej));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
